// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, cause codes and
// the tick-counter sizing helper used by the sequencer and its status/debug consumers.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        StPor     = 2'd0,
        StAssert  = 2'd1,
        StRelease = 2'd2,
        StDone    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CausePor = 2'd0,
        CauseBtn = 2'd1,
        CauseSw  = 2'd2
    } cause_e;

    localparam int unsigned TrigCntW = 8;
    localparam logic [TrigCntW-1:0] TrigCntMax = '1;

    // The shared counter only ever holds values up to max(ticks)-1.
    function automatic int unsigned tick_width(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/reset_seq.sv
// Reset sequencer: power-on delay, hold-in-reset while triggers are active, then
// staggered per-domain release (bit 0 first) followed by a done indication.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned POR_TICKS    = 8,
    parameter int unsigned ASSERT_TICKS = 16,
    parameter int unsigned GAP_TICKS    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn,
    input  logic                sw_req,
    output logic [NUM_CH-1:0]   rst_out,
    output logic                por_done,
    output logic                done,
    output logic [1:0]          cause,
    output logic [TrigCntW-1:0] trig_cnt
);

    localparam int unsigned CntW = tick_width(POR_TICKS, ASSERT_TICKS, GAP_TICKS);

    localparam logic [CntW-1:0] PorLast    = CntW'(POR_TICKS - 1);
    localparam logic [CntW-1:0] AssertLast = CntW'(ASSERT_TICKS - 1);
    localparam logic [CntW-1:0] GapLast    = CntW'(GAP_TICKS - 1);

    state_e          state;
    logic [CntW-1:0] cnt;
    logic            btn_prev;
    logic            btn_rise;
    logic            trigger;
    logic            hold;

    // A trigger is a new button press or a software pulse; a held button only
    // keeps the sequence parked in ASSERT without counting again.
    always_comb begin
        btn_rise = btn & ~btn_prev;
        trigger  = btn_rise | sw_req;
        hold     = btn | sw_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StPor;
            cnt      <= '0;
            btn_prev <= 1'b0;
            rst_out  <= '1;
            por_done <= 1'b0;
            done     <= 1'b0;
            cause    <= CausePor;
            trig_cnt <= '0;
        end else begin
            btn_prev <= btn;

            if (state != StPor && trigger) begin
                cause <= btn ? CauseBtn : CauseSw;
                if (trig_cnt != TrigCntMax) begin
                    trig_cnt <= trig_cnt + TrigCntW'(1);
                end
            end

            unique case (state)
                StPor: begin
                    if (cnt == PorLast) begin
                        state    <= StAssert;
                        cnt      <= '0;
                        por_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end

                StAssert: begin
                    if (hold) begin
                        cnt <= '0;
                    end else if (cnt == AssertLast) begin
                        state   <= StRelease;
                        cnt     <= '0;
                        rst_out <= rst_out << 1;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end

                StRelease: begin
                    if (hold) begin
                        state   <= StAssert;
                        cnt     <= '0;
                        rst_out <= '1;
                    end else if (cnt == GapLast) begin
                        cnt <= '0;
                        // Once every domain is out of reset, one more gap leads to DONE.
                        if (rst_out == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            rst_out <= rst_out << 1;
                        end
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end

                StDone: begin
                    if (hold) begin
                        state   <= StAssert;
                        cnt     <= '0;
                        rst_out <= '1;
                        done    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: directed vector table, hand sequences for the
// multi-cycle corners and a randomized run checked against a release-timeline model.
module tb_reset_seq;

    localparam int unsigned NUM_CH   = 3;
    localparam int          POR_T    = 8;
    localparam int          ASSERT_T = 16;
    localparam int          GAP_T    = 4;

    logic              clk;
    logic              reset;
    logic              btn;
    logic              sw_req;
    logic [NUM_CH-1:0] rst_out;
    logic              por_done;
    logic              done;
    logic [1:0]        cause;
    logic [7:0]        trig_cnt;

    int checks;
    int errors;

    // Reference model: edge count since reset and the edge of the most recent hold.
    int       m_n;
    int       m_hold;
    bit       m_prev;
    int       m_cause;
    int       m_trig;

    reset_seq #(
        .NUM_CH      (NUM_CH),
        .POR_TICKS   (POR_T),
        .ASSERT_TICKS(ASSERT_T),
        .GAP_TICKS   (GAP_T)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn),
        .sw_req  (sw_req),
        .rst_out (rst_out),
        .por_done(por_done),
        .done    (done),
        .cause   (cause),
        .trig_cnt(trig_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         r;
        bit         b;
        bit         s;
        int         cycles;
        logic [2:0] e_rst;
        bit         e_por;
        bit         e_done;
        logic [1:0] e_cause;
        logic [7:0] e_trig;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_n     = 0;
            m_hold  = POR_T;
            m_prev  = 1'b0;
            m_cause = 0;
            m_trig  = 0;
        end else begin
            m_n++;
            if (m_n > POR_T) begin
                if ((btn && !m_prev) || sw_req) begin
                    m_cause = btn ? 1 : 2;
                    if (m_trig < 255) m_trig++;
                end
                if (btn || sw_req) m_hold = m_n;
            end
            m_prev = btn;
        end
    endtask

    task automatic compare_model();
        logic [NUM_CH-1:0] e_rst;
        int d;
        d = m_n - m_hold;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            e_rst[i] = !(d >= ASSERT_T + i * GAP_T);
        end
        check("model_rst_out", 32'(rst_out), 32'(e_rst));
        check("model_por_done", 32'(por_done), 32'(m_n >= POR_T));
        check("model_done", 32'(done), 32'(d >= ASSERT_T + int'(NUM_CH) * GAP_T));
        check("model_cause", 32'(cause), 32'(m_cause));
        check("model_trig_cnt", 32'(trig_cnt), 32'(m_trig));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic drive(input bit r, input bit b, input bit s);
        reset  = r;
        btn    = b;
        sw_req = s;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 1'b0);

        // Edge 0 is the reset edge; row expectations hold after the row's last edge.
        vecs[0]  = '{1, 0, 0, 1,  3'b111, 0, 0, 2'd0, 8'd0};
        vecs[1]  = '{0, 0, 0, 7,  3'b111, 0, 0, 2'd0, 8'd0};
        vecs[2]  = '{0, 0, 0, 1,  3'b111, 1, 0, 2'd0, 8'd0};
        vecs[3]  = '{0, 0, 0, 16, 3'b110, 1, 0, 2'd0, 8'd0};
        vecs[4]  = '{0, 0, 0, 3,  3'b110, 1, 0, 2'd0, 8'd0};
        vecs[5]  = '{0, 0, 0, 1,  3'b100, 1, 0, 2'd0, 8'd0};
        vecs[6]  = '{0, 0, 0, 4,  3'b000, 1, 0, 2'd0, 8'd0};
        vecs[7]  = '{0, 0, 0, 3,  3'b000, 1, 0, 2'd0, 8'd0};
        vecs[8]  = '{0, 0, 0, 1,  3'b000, 1, 1, 2'd0, 8'd0};
        vecs[9]  = '{0, 0, 1, 1,  3'b111, 1, 0, 2'd2, 8'd1};
        vecs[10] = '{0, 0, 0, 16, 3'b110, 1, 0, 2'd2, 8'd1};
        vecs[11] = '{0, 0, 0, 4,  3'b100, 1, 0, 2'd2, 8'd1};
        vecs[12] = '{0, 0, 0, 4,  3'b000, 1, 0, 2'd2, 8'd1};
        vecs[13] = '{0, 0, 0, 4,  3'b000, 1, 1, 2'd2, 8'd1};
        vecs[14] = '{0, 1, 1, 1,  3'b111, 1, 0, 2'd1, 8'd2};
        vecs[15] = '{0, 1, 0, 9,  3'b111, 1, 0, 2'd1, 8'd2};
        vecs[16] = '{0, 0, 0, 16, 3'b110, 1, 0, 2'd1, 8'd2};
        vecs[17] = '{1, 0, 0, 1,  3'b111, 0, 0, 2'd0, 8'd0};
        vecs[18] = '{0, 1, 0, 12, 3'b111, 1, 0, 2'd0, 8'd0};
        vecs[19] = '{0, 0, 0, 15, 3'b111, 1, 0, 2'd0, 8'd0};
        vecs[20] = '{0, 0, 0, 1,  3'b110, 1, 0, 2'd0, 8'd0};

        for (int v = 0; v < 21; v++) begin
            drive(vecs[v].r, vecs[v].b, vecs[v].s);
            run(vecs[v].cycles);
            check($sformatf("vec%0d_rst_out", v), 32'(rst_out), 32'(vecs[v].e_rst));
            check($sformatf("vec%0d_por_done", v), 32'(por_done), 32'(vecs[v].e_por));
            check($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].e_done));
            check($sformatf("vec%0d_cause", v), 32'(cause), 32'(vecs[v].e_cause));
            check($sformatf("vec%0d_trig_cnt", v), 32'(trig_cnt), 32'(vecs[v].e_trig));
        end

        // Button pressed mid-release for 10 cycles starting at edge 31.
        drive(1'b1, 1'b0, 1'b0);
        run(1);
        drive(1'b0, 1'b0, 1'b0);
        run(30);
        drive(1'b0, 1'b1, 1'b0);
        run(1);
        check("btn_reassert_rst", 32'(rst_out), 32'h7);
        check("btn_reassert_cause", 32'(cause), 32'd1);
        check("btn_reassert_trig", 32'(trig_cnt), 32'd1);
        run(9);
        drive(1'b0, 1'b0, 1'b0);
        run(15);
        check("btn_release_early", 32'(rst_out), 32'h7);
        run(1);
        check("btn_release_first", 32'(rst_out), 32'h6);

        // Reset pulsed mid-sequence restarts the whole schedule.
        drive(1'b1, 1'b0, 1'b0);
        run(1);
        drive(1'b0, 1'b0, 1'b0);
        run(29);
        drive(1'b1, 1'b1, 1'b1);
        run(1);
        check("midreset_rst", 32'(rst_out), 32'h7);
        check("midreset_por", 32'(por_done), 32'd0);
        check("midreset_trig", 32'(trig_cnt), 32'd0);
        check("midreset_cause", 32'(cause), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        run(23);
        check("midreset_hold", 32'(rst_out), 32'h7);
        run(1);
        check("midreset_release", 32'(rst_out), 32'h6);

        // Saturation of the trigger counter.
        drive(1'b1, 1'b0, 1'b0);
        run(1);
        drive(1'b0, 1'b0, 1'b0);
        run(POR_T);
        for (int p = 0; p < 256; p++) begin
            drive(1'b0, 1'b0, 1'b1);
            run(1);
            drive(1'b0, 1'b0, 1'b0);
            run(1);
            if (p == 253) check("trig_254", 32'(trig_cnt), 32'd254);
        end
        check("trig_saturated", 32'(trig_cnt), 32'd255);
        check("trig_sat_cause", 32'(cause), 32'd2);

        // Randomized run against the timeline model.
        drive(1'b1, 1'b0, 1'b0);
        run(1);
        for (int c = 0; c < 5000; c++) begin
            bit nb;
            nb = btn;
            if (btn) nb = ($urandom_range(0, 3) != 0);
            else     nb = ($urandom_range(0, 59) == 0);
            drive(($urandom_range(0, 799) == 0), nb, ($urandom_range(0, 49) == 0));
            run(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
